// File: rtl/food_map_pkg.sv
// Shared constants and types for the food map arbiter slice.
package food_map_pkg;

  localparam int COLS       = 80;    // food bits per row, BRAM word width
  localparam int ROWS       = 48;    // valid rows in the map
  localparam int INIT_FOOD  = 2400;  // food count loaded at reset
  localparam int STREAK_MAX = 8;     // display grants allowed while an eat waits

  localparam int ROW_W = 6;          // row / BRAM address width
  localparam int COL_W = 7;          // column index width
  localparam int CNT_W = 12;         // food counter width

  typedef enum logic [1:0] {
    IDLE,
    EAT_RD,
    EAT_CHK,
    EAT_WR
  } state_e;

endpackage

// File: rtl/food_map_if.sv
// Renderer / Pac-Man / BRAM signal bundle around the food map arbiter.
interface food_map_if
  import food_map_pkg::ROW_W, food_map_pkg::COL_W, food_map_pkg::CNT_W;
#(
  parameter int COLS = food_map_pkg::COLS
);

  // renderer row reads
  logic             disp_req;
  logic [ROW_W-1:0] disp_row;
  logic             disp_gnt;
  logic             disp_rvalid;
  logic [COLS-1:0]  disp_rdata;

  // Pac-Man cell clears
  logic             eat_req;
  logic [COL_W-1:0] eat_col;
  logic [ROW_W-1:0] eat_row;
  logic             eat_ack;
  logic             eat_hit;

  // single-port BRAM
  logic             bram_en;
  logic             bram_we;
  logic [ROW_W-1:0] bram_addr;
  logic [COLS-1:0]  bram_wdata;
  logic [COLS-1:0]  bram_rdata;

  // status
  logic [CNT_W-1:0] food_count;
  logic             all_eaten;

  // requesters and BRAM side
  modport master (
    output disp_req, disp_row, eat_req, eat_col, eat_row, bram_rdata,
    input  disp_gnt, disp_rvalid, disp_rdata, eat_ack, eat_hit,
           bram_en, bram_we, bram_addr, bram_wdata, food_count, all_eaten
  );

  // arbiter side
  modport slave (
    input  disp_req, disp_row, eat_req, eat_col, eat_row, bram_rdata,
    output disp_gnt, disp_rvalid, disp_rdata, eat_ack, eat_hit,
           bram_en, bram_we, bram_addr, bram_wdata, food_count, all_eaten
  );

endinterface

// File: rtl/food_counter.sv
// Remaining-food counter: loads LOAD_VAL at reset, saturating decrement to 0.
module food_counter #(
  parameter int W        = 12,
  parameter int LOAD_VAL = 2400
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dec_en,
  output logic [W-1:0] count,
  output logic         zero
);

  // count down on each successful eat, never below zero
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      count <= W'(LOAD_VAL);
    end else if (dec_en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/food_map_arbiter.sv
// Arbitrates the single BRAM port between renderer row reads and atomic
// Pac-Man read-modify-write cell clears, and tracks the remaining food.
module food_map_arbiter
  import food_map_pkg::state_e, food_map_pkg::IDLE, food_map_pkg::EAT_RD,
         food_map_pkg::EAT_CHK, food_map_pkg::EAT_WR,
         food_map_pkg::ROW_W, food_map_pkg::COL_W, food_map_pkg::CNT_W;
#(
  parameter int COLS       = food_map_pkg::COLS,
  parameter int ROWS       = food_map_pkg::ROWS,
  parameter int INIT_FOOD  = food_map_pkg::INIT_FOOD,
  parameter int STREAK_MAX = food_map_pkg::STREAK_MAX
) (
  input logic       clk,
  input logic       rst_n,
  food_map_if.slave bus
);

  localparam int SW = $clog2(STREAK_MAX + 1);

  state_e           state, state_nx;
  logic [SW-1:0]    streak;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [COLS-1:0]  rdata_q;
  logic [COLS-1:0]  held_q;
  logic [COLS-1:0]  clr_mask;
  logic             rvalid_q;
  logic             oor_ack_q;
  logic             eat_gnt;
  logic             disp_gnt_c;
  logic             eat_oor;
  logic             dec_en;

  assign eat_oor  = (int'(bus.eat_col) >= COLS) || (int'(bus.eat_row) >= ROWS);
  assign clr_mask = {{(COLS-1){1'b0}}, 1'b1} << col_q;

  // IDLE arbitration: eat wins when display is quiet or has used its streak
  always_comb begin
    eat_gnt    = 1'b0;
    disp_gnt_c = 1'b0;
    // NOTE: grants are qualified with rst_n so no request can reach the
    // BRAM port while reset is held, even though state is already IDLE.
    if (rst_n && (state == IDLE)) begin
      // an out-of-range ack leaves eat_req high for one more cycle; do not
      // re-grant that same request while its ack is on the wire
      if (bus.eat_req && !oor_ack_q &&
          (!bus.disp_req || (streak == SW'(STREAK_MAX)))) begin
        eat_gnt = 1'b1;
      end else if (bus.disp_req) begin
        disp_gnt_c = 1'b1;
      end
    end
  end

  // next state and BRAM / handshake outputs
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned and no latch is inferred.
    state_nx       = state;
    bus.disp_gnt   = 1'b0;
    bus.bram_en    = 1'b0;
    bus.bram_we    = 1'b0;
    bus.bram_addr  = '0;
    bus.bram_wdata = '0;
    bus.eat_ack    = oor_ack_q;
    bus.eat_hit    = 1'b0;
    dec_en         = 1'b0;
    case (state)
      IDLE: begin
        if (disp_gnt_c) begin
          bus.disp_gnt  = 1'b1;
          bus.bram_en   = 1'b1;
          bus.bram_addr = bus.disp_row;
        end else if (eat_gnt && !eat_oor) begin
          bus.bram_en   = 1'b1;
          bus.bram_addr = bus.eat_row;
          state_nx      = EAT_RD;
        end
      end
      EAT_RD: begin
        state_nx = EAT_CHK;
      end
      EAT_CHK: begin
        if (rdata_q[col_q]) begin
          state_nx = EAT_WR;
        end else begin
          bus.eat_ack = 1'b1;
          state_nx    = IDLE;
        end
      end
      EAT_WR: begin
        bus.bram_en    = 1'b1;
        bus.bram_we    = 1'b1;
        bus.bram_addr  = row_q;
        bus.bram_wdata = rdata_q & ~clr_mask;
        bus.eat_ack    = 1'b1;
        bus.eat_hit    = 1'b1;
        dec_en         = 1'b1;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // capture the target cell at grant and the row word once it arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      rdata_q   <= '0;
      oor_ack_q <= 1'b0;
    end else begin
      oor_ack_q <= eat_gnt && eat_oor;
      if (eat_gnt && !eat_oor) begin
        col_q <= bus.eat_col;
        row_q <= bus.eat_row;
      end
      if (state == EAT_RD) rdata_q <= bus.bram_rdata;
    end
  end

  // display-grant streak while an eat is waiting, saturating at STREAK_MAX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (eat_gnt || !bus.eat_req) begin
      streak <= '0;
    end else if (disp_gnt_c && (streak != SW'(STREAK_MAX))) begin
      streak <= streak + 1'b1;
    end
  end

  // display read return: pulse one cycle after grant, hold last word after
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      held_q   <= '0;
    end else begin
      rvalid_q <= disp_gnt_c;
      if (rvalid_q) held_q <= bus.bram_rdata;
    end
  end

  assign bus.disp_rvalid = rvalid_q;
  assign bus.disp_rdata  = rvalid_q ? bus.bram_rdata : held_q;

  food_counter #(
    .W        (CNT_W),
    .LOAD_VAL (INIT_FOOD)
  ) u_food_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .dec_en (dec_en),
    .count  (bus.food_count),
    .zero   (bus.all_eaten)
  );

endmodule

// File: tb/tb_food_map_arbiter.sv
// Scoreboard bench for food_map_arbiter: a BRAM model, a cell-level food
// map reference, directed scenarios and a randomized phase. A second
// instance with a tiny initial count exercises counter saturation.
module tb_food_map_arbiter;
  import food_map_pkg::*;

  typedef struct {
    int col;
    int row;
  } eat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  food_map_if bus ();
  food_map_if bus2 ();

  food_map_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  food_map_arbiter #(.INIT_FOOD(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  // BRAM model: one-cycle read latency, read-before-write
  logic [COLS-1:0] mem [64];
  logic [COLS-1:0] bram_q = '0;
  assign bus.bram_rdata  = bram_q;
  assign bus2.bram_rdata = '1;  // second instance sees a completely full map

  always @(posedge clk) begin
    if (bus.bram_en) begin
      if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_wdata;
      bram_q <= mem[bus.bram_addr];
    end
  end

  // reference model and scoreboard state
  logic [COLS-1:0] ref_map [64];
  int              ref_count;
  eat_t            eat_q[$];
  logic [COLS-1:0] disp_q[$];
  int              checks = 0;
  int              errors = 0;
  int              rvalid_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: compares every DUT response against the reference model
  bit              prev_gnt = 1'b0;
  logic [COLS-1:0] last_rdata = '0;
  eat_t            mon_e;
  logic [COLS-1:0] mon_exp;
  logic [COLS-1:0] mon_row;
  bit              mon_hit;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt   = 1'b0;
      last_rdata = '0;
    end else begin
      check("food_count", bus.food_count, ref_count);
      check("all_eaten", bus.all_eaten, ref_count == 0);
      if (prev_gnt || bus.disp_rvalid) check("rvalid_timing", bus.disp_rvalid, prev_gnt);
      if (bus.disp_rvalid) begin
        rvalid_cnt++;
        if (disp_q.size() == 0) begin
          check("disp_unexpected_rvalid", 1'b1, 1'b0);
        end else begin
          mon_exp = disp_q.pop_front();
          check("disp_rdata", bus.disp_rdata, mon_exp);
          last_rdata = mon_exp;
        end
      end else begin
        check("disp_rdata_hold", bus.disp_rdata, last_rdata);
      end
      if (bus.eat_ack) begin
        if (eat_q.size() == 0) begin
          check("eat_unexpected_ack", 1'b1, 1'b0);
        end else begin
          mon_e   = eat_q.pop_front();
          mon_hit = 1'b0;
          if (mon_e.col < COLS && mon_e.row < ROWS) mon_hit = ref_map[mon_e.row][mon_e.col];
          check("eat_hit", bus.eat_hit, mon_hit);
          check("eat_we", bus.bram_we, mon_hit);
          if (mon_hit) begin
            mon_row = ref_map[mon_e.row];
            mon_row[mon_e.col] = 1'b0;
            check("wr_addr", bus.bram_addr, mon_e.row);
            check("wr_data", bus.bram_wdata, mon_row);
            ref_map[mon_e.row] = mon_row;
            if (ref_count > 0) ref_count--;
          end
        end
      end else begin
        check("no_we_without_ack", bus.bram_we, 1'b0);
      end
      if (bus.disp_gnt) disp_q.push_back(ref_map[bus.disp_row]);
      prev_gnt = bus.disp_gnt;
    end
  end

  // directed eat with no competing display traffic
  task automatic eat_directed(input int col, input int row, input int exp_count, input string tag);
    int   n;
    int   en_cnt = 0;
    int   exp_lat;
    bit   done = 1'b0;
    eat_t e;
    if (col >= COLS || row >= ROWS) exp_lat = 1;
    else                            exp_lat = ref_map[row][col] ? 3 : 2;
    @(posedge clk); #1;
    bus.eat_col = 7'(col);
    bus.eat_row = 6'(row);
    bus.eat_req = 1'b1;
    e.col = col;
    e.row = row;
    eat_q.push_back(e);
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.bram_en) en_cnt++;
      if (bus.eat_ack) begin
        done = 1'b1;
        break;
      end
    end
    check({tag, "_ack_seen"}, done, 1'b1);
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_bram_en_cycles"}, en_cnt, (exp_lat == 1) ? 0 : (exp_lat == 3 ? 2 : 1));
    @(posedge clk); #1;
    bus.eat_req = 1'b0;
    @(negedge clk);
    if (exp_count >= 0) check({tag, "_count"}, bus.food_count, exp_count);
  endtask

  // single display read of one row
  task automatic disp_one(input int row);
    @(posedge clk); #1;
    bus.disp_req = 1'b1;
    bus.disp_row = 6'(row);
    @(negedge clk);
    check("disp_one_gnt", bus.disp_gnt, 1'b1);
    @(posedge clk); #1;
    bus.disp_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // display held continuously while an eat waits
  task automatic streak_test(input int col, input int row);
    int   n;
    int   gnts = 0;
    int   exp_lat;
    bit   done = 1'b0;
    eat_t e;
    exp_lat = STREAK_MAX + (ref_map[row][col] ? 3 : 2);
    @(posedge clk); #1;
    bus.disp_req = 1'b1;
    bus.disp_row = 6'($urandom_range(0, ROWS - 1));
    bus.eat_col  = 7'(col);
    bus.eat_row  = 6'(row);
    bus.eat_req  = 1'b1;
    e.col = col;
    e.row = row;
    eat_q.push_back(e);
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.eat_ack) begin
        done = 1'b1;
        break;
      end
      if (bus.disp_gnt) gnts++;
      @(posedge clk); #1;
      bus.disp_row = 6'($urandom_range(0, ROWS - 1));
    end
    check("streak_ack_seen", done, 1'b1);
    check("streak_disp_grants", gnts, STREAK_MAX);
    check("streak_ack_latency", n, exp_lat);
    @(posedge clk); #1;
    bus.eat_req = 1'b0;
    @(negedge clk);
    check("streak_disp_resume", bus.disp_gnt, 1'b1);
    @(posedge clk); #1;
    bus.disp_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // reset asserted while the arbiter sits in EAT_CHK
  task automatic reset_abort(input int col, input int row);
    eat_t e;
    @(posedge clk); #1;
    bus.eat_col = 7'(col);
    bus.eat_row = 6'(row);
    bus.eat_req = 1'b1;
    e.col = col;
    e.row = row;
    eat_q.push_back(e);
    @(negedge clk);  // grant
    @(negedge clk);  // EAT_RD
    @(posedge clk); #2;  // inside EAT_CHK
    rst_n = 1'b0;
    eat_q.delete();
    ref_count = INIT_FOOD;
    #1;
    check("abort_we", bus.bram_we, 1'b0);
    check("abort_en", bus.bram_en, 1'b0);
    check("abort_ack", bus.eat_ack, 1'b0);
    check("abort_count", bus.food_count, INIT_FOOD);
    bus.eat_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("abort_hold_we", bus.bram_we, 1'b0);
      check("abort_hold_ack", bus.eat_ack, 1'b0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_count_after", bus.food_count, INIT_FOOD);
  endtask

  initial begin
    int   r0;
    int   col;
    int   row;
    int   pend;
    bit   ack_seen;
    eat_t e;
    int   cnt2;
    int   exp2;
    bit   done2;

    // map contents: random rows with the cells the scenarios rely on pinned
    for (int r = 0; r < 64; r++) mem[r] = {$urandom, $urandom, $urandom};
    mem[27][38] = 1'b1;
    mem[23][29] = 1'b1;
    mem[47][79] = 1'b1;
    mem[10][5]  = 1'b0;
    for (int r = 0; r < 64; r++) ref_map[r] = mem[r];
    ref_count = INIT_FOOD;

    bus2.disp_req = 1'b0;
    bus2.disp_row = '0;
    bus2.eat_req  = 1'b0;
    bus2.eat_col  = '0;
    bus2.eat_row  = '0;

    // reset with both requesters active: nothing may leak out
    bus.disp_req = 1'b1;
    bus.disp_row = 6'd3;
    bus.eat_req  = 1'b1;
    bus.eat_col  = 7'd5;
    bus.eat_row  = 6'd5;
    #23;
    check("rst_disp_gnt", bus.disp_gnt, 1'b0);
    check("rst_disp_rvalid", bus.disp_rvalid, 1'b0);
    check("rst_eat_ack", bus.eat_ack, 1'b0);
    check("rst_eat_hit", bus.eat_hit, 1'b0);
    check("rst_bram_en", bus.bram_en, 1'b0);
    check("rst_bram_we", bus.bram_we, 1'b0);
    check("rst_bram_addr", bus.bram_addr, 0);
    check("rst_bram_wdata", bus.bram_wdata, 0);
    check("rst_disp_rdata", bus.disp_rdata, 0);
    check("rst_food_count", bus.food_count, INIT_FOOD);
    check("rst_all_eaten", bus.all_eaten, 1'b0);
    bus.disp_req = 1'b0;
    bus.eat_req  = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // eat a set cell, then the same cell again
    eat_directed(38, 27, INIT_FOOD - 1, "eat_hit_38_27");
    eat_directed(38, 27, INIT_FOOD - 1, "eat_again_38_27");
    disp_one(27);

    // empty cell and out-of-range cells
    eat_directed(5, 10, INIT_FOOD - 1, "eat_miss_5_10");
    eat_directed(80, 5, INIT_FOOD - 1, "eat_col_oor");
    eat_directed(3, 50, INIT_FOOD - 1, "eat_row_oor");

    // back-to-back display reads of rows 0..5
    r0 = rvalid_cnt;
    @(posedge clk); #1;
    bus.disp_req = 1'b1;
    for (int r = 0; r < 6; r++) begin
      bus.disp_row = 6'(r);
      @(negedge clk);
      check("burst_gnt", bus.disp_gnt, 1'b1);
      @(posedge clk); #1;
    end
    bus.disp_req = 1'b0;
    repeat (2) @(negedge clk);
    check("burst_rvalid_count", rvalid_cnt - r0, 6);

    // display starvation bound
    streak_test(29, 23);

    // reset in the middle of a read-modify-write, then check the cell survived
    reset_abort(79, 47);
    disp_one(47);
    eat_directed(79, 47, INIT_FOOD - 1, "eat_corner_79_47");

    // randomized mixed traffic
    ack_seen = 1'b0;
    pend     = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      bus.disp_req = ($urandom_range(0, 99) < 60);
      bus.disp_row = 6'($urandom_range(0, ROWS - 1));
      if (ack_seen) begin
        bus.eat_req = 1'b0;
        ack_seen    = 1'b0;
        pend        = 0;
      end else if (!bus.eat_req && $urandom_range(0, 99) < 25) begin
        if ($urandom_range(0, 9) == 0) begin
          col = $urandom_range(COLS, 127);
          row = $urandom_range(0, 63);
        end else begin
          row = $urandom_range(0, ROWS - 1);
          col = $urandom_range(0, COLS - 1);
          for (int t = 0; t < 6 && !ref_map[row][col]; t++) col = $urandom_range(0, COLS - 1);
        end
        bus.eat_col = 7'(col);
        bus.eat_row = 6'(row);
        bus.eat_req = 1'b1;
        e.col = col;
        e.row = row;
        eat_q.push_back(e);
      end
      @(negedge clk);
      if (bus.eat_req) begin
        pend++;
        if (bus.eat_ack) ack_seen = 1'b1;
        if (pend > 40) begin
          check("rand_eat_timeout", 1'b1, 1'b0);
          ack_seen = 1'b1;
          eat_q.delete();
        end
      end
    end
    @(posedge clk); #1;
    bus.disp_req = 1'b0;
    bus.eat_req  = 1'b0;
    repeat (4) @(negedge clk);
    check("drain_eat_q", eat_q.size(), 0);
    check("drain_disp_q", disp_q.size(), 0);

    // counter saturation on the small instance (its BRAM always reads full)
    cnt2 = 2;
    check("sat_initial", bus2.food_count, cnt2);
    for (int i = 0; i < 3; i++) begin
      exp2  = (cnt2 > 0) ? cnt2 - 1 : 0;
      done2 = 1'b0;
      @(posedge clk); #1;
      bus2.eat_col = 7'(i);
      bus2.eat_row = 6'(i);
      bus2.eat_req = 1'b1;
      for (int n = 0; n < 20 && !done2; n++) begin
        @(negedge clk);
        if (bus2.eat_ack) begin
          done2 = 1'b1;
          check("sat_hit", bus2.eat_hit, 1'b1);
        end
      end
      check("sat_ack_seen", done2, 1'b1);
      @(posedge clk); #1;
      bus2.eat_req = 1'b0;
      @(negedge clk);
      check("sat_count", bus2.food_count, exp2);
      check("sat_all_eaten", bus2.all_eaten, exp2 == 0);
      cnt2 = exp2;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
